// File: rtl/fp_operand_unpack_pkg.sv
// Shared definitions for the FP add/sub operand front end: error classes,
// the single-precision field view, FIFO sizing and the stored entry layout.
package addpkg;

   localparam logic [7:0] EXP_MAX    = 8'hFF;
   localparam int         FIFO_DEPTH = 2;
   localparam int         CNT_W      = $clog2(FIFO_DEPTH + 1);
   localparam int         PTR_W      = $clog2(FIFO_DEPTH);

   // Pre-classification handed to the adder alongside the operands
   typedef enum logic [2:0] {
      ERR_NONE    = 3'b000,
      ERR_NAN     = 3'b001,
      ERR_INVALID = 3'b010,
      ERR_INF     = 3'b011,
      ERR_DENORM  = 3'b100
   } err_e;

   // IEEE-754 single precision, most significant field first
   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } fp_t;

   // One buffered operand pair as presented to the adder
   typedef struct packed {
      fp_t  op1;
      fp_t  op2;
      logic opcode;
      err_e error;
   } entry_t;

   // Priority encode the per-operand classes into one pair class.
   // An add of opposite-signed infinities (or a subtract of like-signed
   // ones) has no defined result, hence the sign/opcode parity term.
   function automatic err_e pair_error(
      input logic [1:0] is_nan,
      input logic [1:0] is_inf,
      input logic [1:0] is_denorm,
      input logic       sign1,
      input logic       sign2,
      input logic       sub
   );
      err_e result;
      if (|is_nan) begin
         result = ERR_NAN;
      end else if ((&is_inf) && (sign1 ^ sign2 ^ sub)) begin
         result = ERR_INVALID;
      end else if (|is_inf) begin
         result = ERR_INF;
      end else if (|is_denorm) begin
         result = ERR_DENORM;
      end else begin
         result = ERR_NONE;
      end
      return result;
   endfunction

endpackage

// File: rtl/fp_operand_unpack_classify.sv
// fp_classify: purely combinational class flags for one single-precision
// operand. Exactly one of the flags is set for NaN, infinity, zero or
// denormal inputs; all are clear for a normal number.
module fp_classify
   import addpkg::*;
(
   input  fp_t  op,
   output logic is_nan,
   output logic is_inf,
   output logic is_zero,
   output logic is_denorm
);

   logic exp_all_ones;
   logic exp_all_zero;
   logic frac_nonzero;

   assign exp_all_ones = (op.exp == EXP_MAX);
   assign exp_all_zero = (op.exp == 8'h00);
   assign frac_nonzero = |op.frac;

   assign is_nan    = exp_all_ones &  frac_nonzero;
   assign is_inf    = exp_all_ones & ~frac_nonzero;
   assign is_zero   = exp_all_zero & ~frac_nonzero;
   assign is_denorm = exp_all_zero &  frac_nonzero;

endmodule

// File: rtl/fp_operand_unpack.sv
// fp_operand_unpack: accepts IEEE-754 single-precision operand pairs,
// splits them into sign/exponent/fraction, pre-classifies the pair and
// buffers it in a 2-entry in-order FIFO in front of the adder.
// Build option: define FP_DENORM_FLUSH_EN to present denormal operands as
// signed zero; otherwise denormals pass through unchanged. The error class
// is the same in both builds.
module fp_operand_unpack
   import addpkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] op1_bits,
   input  logic [31:0] op2_bits,
   input  logic        opcode_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        sign1,
   output logic        sign2,
   output logic [7:0]  exp1,
   output logic [7:0]  exp2,
   output logic [22:0] sig1,
   output logic [22:0] sig2,
   output logic        opcode,
   output err_e        error,
   output logic [15:0] op_count
);

`ifdef FP_DENORM_FLUSH_EN
   localparam logic DENORM_FLUSH = 1'b1;
`else
   localparam logic DENORM_FLUSH = 1'b0;
`endif

   localparam logic [15:0] OP_COUNT_MAX = 16'hFFFF;

   fp_t              op_in    [2];
   fp_t              op_canon [2];
   logic [1:0]       is_nan;
   logic [1:0]       is_inf;
   logic [1:0]       is_zero;
   logic [1:0]       is_denorm;

   entry_t           entry_next;
   entry_t           head;
   entry_t           mem_reg  [FIFO_DEPTH];

   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_next;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;
   logic             in_ready_reg;
   logic             in_ready_next;
   logic [15:0]      op_count_reg;
   logic [15:0]      op_count_next;

   logic             push;
   logic             pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
   endfunction

   assign op_in[0] = op1_bits;
   assign op_in[1] = op2_bits;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_operand
         fp_classify u_classify (
            .op        (op_in[gi]),
            .is_nan    (is_nan[gi]),
            .is_inf    (is_inf[gi]),
            .is_zero   (is_zero[gi]),
            .is_denorm (is_denorm[gi])
         );

         // Zeros and (optionally) flushed denormals leave as a signed zero
         assign op_canon[gi] = (is_zero[gi] | (DENORM_FLUSH & is_denorm[gi]))
                               ? {op_in[gi].sign, 31'h0}
                               : op_in[gi];
      end
   endgenerate

   // The class is taken from the raw operands so flushing never hides a denormal
   assign entry_next.op1    = op_canon[0];
   assign entry_next.op2    = op_canon[1];
   assign entry_next.opcode = opcode_in;
   assign entry_next.error  = pair_error(is_nan, is_inf, is_denorm,
                                         op_in[0].sign, op_in[1].sign, opcode_in);

   assign push = in_valid & in_ready_reg;
   assign pop  = (count_reg != '0) & out_ready;

   // Next-state for pointers, occupancy, ready and the accept counter
   always_comb begin
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      count_next    = count_reg;
      op_count_next = op_count_reg;

      if (push) begin
         wr_ptr_next = ptr_inc(wr_ptr_reg);
         if (op_count_reg != OP_COUNT_MAX) begin
            op_count_next = op_count_reg + 16'd1;
         end
      end

      if (pop) begin
         rd_ptr_next = ptr_inc(rd_ptr_reg);
      end

      case ({push, pop})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase

      // Ready is registered, so it looks at the occupancy after this edge
      in_ready_next = (count_next != CNT_W'(FIFO_DEPTH));
   end

   // Control registers; reset drops every buffered pair and holds off input
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         in_ready_reg <= 1'b0;
         op_count_reg <= '0;
      end else begin
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         count_reg    <= count_next;
         in_ready_reg <= in_ready_next;
         op_count_reg <= op_count_next;
      end
   end

   // Pair storage is written only on push, so the head holds under backpressure
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else if (push) begin
         mem_reg[wr_ptr_reg] <= entry_next;
      end
   end

   assign head      = mem_reg[rd_ptr_reg];

   assign in_ready  = in_ready_reg;
   assign out_valid = (count_reg != '0);
   assign op_count  = op_count_reg;

   assign sign1     = head.op1.sign;
   assign exp1      = head.op1.exp;
   assign sig1      = head.op1.frac;
   assign sign2     = head.op2.sign;
   assign exp2      = head.op2.exp;
   assign sig2      = head.op2.frac;
   assign opcode    = head.opcode;
   assign error     = head.error;

endmodule

// File: doc/fp_operand_unpack.md
FP_OPERAND_UNPACK -- requirements
Module: fp_operand_unpack

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is synchronous and active-high.
REQ-002 Ports, clock and reset first (name  direction  width  meaning):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  upstream offers an operand pair.
- in_ready  out  1  block accepts the pair this cycle.
- op1_bits  in  32  IEEE-754 single-precision operand 1.
- op2_bits  in  32  IEEE-754 single-precision operand 2.
- opcode_in  in  1  0 = add, 1 = subtract.
- out_valid  out  1  unpacked pair is presented to the adder.
- out_ready  in  1  adder consumes the pair this cycle.
- sign1, sign2  out  1 each  operand signs.
- exp1, exp2  out  8 each  biased exponents.
- sig1, sig2  out  23 each  stored fractions, no hidden bit.
- opcode  out  1  registered opcode_in.
- error  out  3  err_e pre-classification of the pair.
- op_count  out  16  count of accepted pairs, saturating.

Function
REQ-003 A transfer SHALL occur on a rising edge when in_valid && in_ready; a pop SHALL occur when out_valid && out_ready.
REQ-004 Storage SHALL be a 2-entry in-order FIFO. in_ready = (count != 2), registered. out_valid = (count != 0).
REQ-005 Latency SHALL be 1 cycle: a pair accepted at edge N into an empty FIFO SHALL be presented with out_valid at edge N+1.
REQ-006 Push and pop together at count 1 SHALL leave count at 1. The new pair becomes head on the following cycle.
REQ-007 At count 2, in_ready SHALL be 0 and no push occurs. A pop at count 2 SHALL raise in_ready on the next cycle.
REQ-008 While out_valid && !out_ready, all data outputs SHALL hold stable.
REQ-009 Field extraction SHALL be: sign = bits[31], exponent = bits[30:23], fraction = bits[22:0].
REQ-010 error SHALL be computed at push time with this priority:
- ERR_NAN (001): either operand has exp 0xFF and fraction != 0.
- ERR_INVALID (010): both operands infinite, and (sign1 ^ sign2 ^ opcode_in) == 1.
- ERR_INF (011): any operand infinite.
- ERR_DENORM (100): any operand has exp 0 and fraction != 0.
- ERR_NONE (000): none of the above.
REQ-011 op_count SHALL increment by 1 per accepted pair and saturate at 0xFFFF.

Reset
REQ-012 In any cycle where reset = 1, the following SHALL be 0 on the next edge: count, out_valid, in_ready, all data outputs, error, and op_count.
REQ-013 Reset mid-operation SHALL discard all buffered pairs; no pair accepted before reset SHALL appear after it.
REQ-014 in_ready SHALL rise on the first edge after reset deasserts.

Configuration
REQ-015 Macro FP_DENORM_FLUSH_EN SHALL control denormal handling.
- Defined: a denormal operand SHALL be output as signed zero (exp 0, fraction 0, sign kept), and error = ERR_DENORM unless a higher priority applies.
- Undefined: denormals SHALL pass through unmodified with the same error classification.

Structure
REQ-016 Package addpkg SHALL hold err_e (3-bit enum), the constants EXP_MAX = 8'hFF and FIFO_DEPTH = 2, and the existing fp_t type.
REQ-017 Per-operand classification SHALL be a combinational sub-module fp_classify, instantiated twice, with outputs is_nan, is_inf, is_zero and is_denorm.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Basic unpack: op1 0x3E99999A (0.3), op2 0xC0200000 (-2.5), opcode 0, out_ready 1 -> next cycle: sign1 0, exp1 0x7D, sig1 0x19999A; sign2 1, exp2 0x80, sig2 0x200000; error 000.
- Invalid: op1 0x7F800000, op2 0xFF800000, opcode 0 -> error 010. Same with op2 0x7F800000 and opcode 1 -> 010. With op2 0x7F800000 and opcode 0 -> 011.
- NaN priority: op1 0x7FC00000, op2 0xFF800000 -> error 001.
- Denormal: op1 0x80000001 -> error 100. With FP_DENORM_FLUSH_EN: sign1 1, exp1 0, sig1 0. Without: sig1 0x000001.
- Backpressure: out_ready 0, three back-to-back valid pairs -> first two accepted, in_ready 0 on the cycle after the second. Raise out_ready -> pairs emerge in order and the third is accepted one cycle after the first pop.
- Reset with two buffered pairs -> out_valid 0 and op_count 0 after the edge. Drive 70000 accepts -> op_count 0xFFFF.
